uart_param_rx: RTL and testbench
================================

# uart_param_rx

Parametrised UART receiver, the successor to the fixed 8N1 constant-baud receiver. It adds configurable data width, parity and stop bits. It also adds an input synchroniser, false-start rejection, and parity, framing and overrun error reporting. It sits between the board RX pin and the command parser, exposing a one-word holding register with a sticky `data_rec` flag cleared by `clr`.

## Interface
- `clock_freq`, 100_000_000: system clock frequency in Hz.
- `baud_rate`, 115200: line rate. `baud_limit = clock_freq / baud_rate`, integer division; must be ≥ 4.
- `data_bits`, 8: payload bits per frame, 5..9.
- `parity_mode`, 0: 0 = none, 1 = odd, 2 = even.
- `stop_bits`, 1: 1 or 2.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx`  in  1: asynchronous serial line, idle high.
- `clr`  in  1: clears `data_rec`, `parity_err`, `frame_err`, `overrun_err`.
- `data`  out  `data_bits`: last received word, LSB first on the line. Reset: all ones.
- `data_rec`  out  1: word valid, sticky. Reset: 0.
- `parity_err`  out  1: parity mismatch on the last word. Reset: 0.
- `frame_err`  out  1: a stop bit was sampled low on the last word. Reset: 0.
- `overrun_err`  out  1: a word completed while `data_rec` was still set. Sticky. Reset: 0.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised `rx_s`.
- **Baud counter:** width `$clog2(baud_limit)`. Counts 0..`baud_limit-1` and wraps. It is held at 0 in IDLE. Mid-bit point `half = baud_limit/2`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `rx_s == 0` → START, counter cleared.
  - START: at the sample point, bit = 1 → IDLE (false start, no flags touched); bit = 0 → DATA.
  - DATA: shift the sampled bit into the MSB of the shift register (LSB first). After `data_bits` samples → PARITY if `parity_mode != 0`, else STOP.
  - PARITY: the sampled bit is compared against the XOR of the data bits. Odd mode: expected = ~XOR. Even mode: expected = XOR. Then → STOP.
  - STOP: sample `stop_bits` bits; any 0 marks a framing error. After the last stop sample → IDLE, commit.
- **Commit** happens on the edge of the last stop sample:
  - `data` ← shift register.
  - `data_rec` ← 1.
  - `parity_err` and `frame_err` are overwritten with this frame's result.
  - `overrun_err` ← 1 if `data_rec` was 1 and `clr` was 0 on that edge.
- **`clr` and commit in the same cycle:** commit wins for `data_rec`, `parity_err` and `frame_err`; `overrun_err` is cleared.
- **`clr` alone:** clears all four flags and leaves `data` unchanged.
- **Framing error handling:** the word is still committed. If the line remains low, IDLE re-enters START immediately and the false-start check governs.
- **Reset mid-frame:** `rst` aborts the frame. FSM → IDLE, counters 0, shift register all ones, outputs at reset values. The next frame is accepted only after `rx_s` has been seen high and then low.

## Timing
- Pin-to-detect latency: 2 cycles through the synchroniser, plus 1 cycle for IDLE→START.
- Sample point: counter == `half` in each bit period, measured from START entry.
- With majority voting enabled, the decision is taken at `half+1`.
- `data_rec` rises 1 cycle after the commit edge. Relative to the synchronised start edge, that is ≈ `(1 + data_bits + P + stop_bits - 1) × baud_limit + half + 1` cycles, where P is 0 or 1 for parity.
- A new frame may start in the cycle after commit; no extra idle time is required beyond the stop-bit remainder.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Samples `rx_s` at counter `half-1`, `half` and `half+1`.
  - The bit value is the 2-of-3 majority.
  - The decision, shift, state change and commit occur at `half+1`.
- `UART_RX_MAJORITY_EN` undefined:
  - Single sample at `half`; all actions occur at `half`.
  - No extra sample registers.

## Test plan
- Parameters: `clock_freq` = 1_000_000, `baud_rate` = 100_000 (`baud_limit` = 10), 8N1. Send 0xA5 → `data` = 0xA5; `data_rec` = 1, all error flags 0. Pulse `clr` → `data_rec` = 0, `data` still 0xA5.
- Even parity, 8E1: send 0x03 with parity bit 1 → `parity_err` = 1. Resend with parity 0 → `parity_err` = 0, `data` = 0x03.
- `stop_bits` = 2: second stop bit driven low, word 0x5A → `data` = 0x5A, `data_rec` = 1, `frame_err` = 1. Next good frame 0x11 → `frame_err` = 0.
- Glitch: `rx` low for 3 cycles → FSM returns to IDLE, no flags set. A following valid 0x3C is received correctly.
- Two frames 0x01, 0x02 sent back-to-back without `clr` → `data` = 0x02, `overrun_err` = 1. Repeat with `clr` asserted on the second commit edge → `overrun_err` = 0, `data_rec` = 1.
- Assert `rst` during bit 4 of a frame → all outputs at reset values. The remainder of that frame produces no commit; the next frame 0xC3 is received correctly.
- With `UART_RX_MAJORITY_EN` defined, a 1-cycle inverted glitch at counter == `half` on bit 0 of 0x00 → `data` = 0x00.

Source files
------------

// File: rtl/uart_param_rx.sv
// Parametrised UART receiver: configurable data width, parity and stop bits, error flags and a sticky holding register.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority vote around the bit centre).
module uart_param_rx #(
    parameter int clock_freq  = 100_000_000,
    parameter int baud_rate   = 115200,
    parameter int data_bits   = 8,
    parameter int parity_mode = 0,
    parameter int stop_bits   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 clr,
    output logic [data_bits-1:0] data,
    output logic                 data_rec,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic [2:0]           o_dbg_state
);

    localparam int BAUD_LIMIT = clock_freq / baud_rate;
    localparam int CNT_W      = $clog2(BAUD_LIMIT);
    localparam int HALF       = BAUD_LIMIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int TICK       = HALF + 1;
`else
    localparam int TICK       = HALF;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BAUD_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_TICK  = CNT_W'(TICK);
    localparam logic [3:0]       BIT_LAST  = 4'(data_bits - 1);
    localparam logic             STOP_LAST = 1'(stop_bits - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [1:0]           r_sync;
    logic [1:0]           r_fill;
    logic                 r_armed;
    logic                 w_rx_s;

    logic [CNT_W-1:0]     r_cnt;
    logic                 w_tick;
    logic                 w_bit;

    logic [data_bits-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 w_par_exp;

    logic                 w_shift;
    logic                 w_par_cap;
    logic                 w_stop_smp;
    logic                 w_commit;

    // r_fill marks when the synchroniser holds real pin samples again after reset;
    // r_armed requires the line to be seen high before a start edge is honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_fill <= {r_fill[0], 1'b1};
            if (r_fill[1] && w_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tick = (r_cnt == CNT_TICK);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_SMP_A = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_SMP_B = CNT_W'(HALF);

    logic r_smp_a;
    logic r_smp_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_a <= 1'b1;
            r_smp_b <= 1'b1;
        end else begin
            if (r_cnt == CNT_SMP_A) begin
                r_smp_a <= w_rx_s;
            end
            if (r_cnt == CNT_SMP_B) begin
                r_smp_b <= w_rx_s;
            end
        end
    end

    // Third vote is the live sample at the decision point.
    assign w_bit = (r_smp_a & r_smp_b) | (r_smp_a & w_rx_s) | (r_smp_b & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_par_cap   = 1'b0;
        w_stop_smp  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = (parity_mode != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_par_cap   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_stop_smp = 1'b1;
                    if (r_stop_cnt == STOP_LAST) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_par_exp = (parity_mode == 1) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '1;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_shift) begin
                r_shift <= {w_bit, r_shift[data_bits-1:1]};
            end

            if (r_state != S_STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (w_stop_smp) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
            end else begin
                if (w_par_cap) begin
                    r_par_err <= (w_bit != w_par_exp);
                end
                if (w_stop_smp && !w_bit) begin
                    r_frm_err <= 1'b1;
                end
            end
        end
    end

    // A commit beats a simultaneous clr for the per-word flags; clr still drops overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= '1;
            data_rec    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (w_commit) begin
            data        <= r_shift;
            data_rec    <= 1'b1;
            parity_err  <= r_par_err;
            frame_err   <= r_frm_err | ~w_bit;
            overrun_err <= clr ? 1'b0 : (overrun_err | data_rec);
        end else if (clr) begin
            data_rec    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_param_rx.sv
// Bench for uart_param_rx: four receivers (8N1, 8E1, 8N2, 7O1) driven by a bit-level line model.
`timescale 1ns/1ps
module tb_uart_param_rx;

    localparam int CF   = 1_000_000;
    localparam int BR   = 100_000;
    localparam int BL   = CF / BR;
    localparam int HALF = BL / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ  = 1;
`else
    localparam int MAJ  = 0;
`endif
    localparam int NU = 4;
    localparam int DB[NU] = '{8, 8, 8, 7};
    localparam int PM[NU] = '{0, 2, 0, 1};
    localparam int SB[NU] = '{1, 1, 2, 1};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NU-1:0] rx_v = '1;
    logic [NU-1:0] clr_v = '0;

    wire  [7:0]    d0, d1, d2;
    wire  [6:0]    d3;
    wire  [NU-1:0] rec_w, perr_w, ferr_w, ovr_w;
    wire  [2:0]    st0, st1, st2, st3;

    logic [8:0]    exp_data [NU];
    logic          exp_rec  [NU];
    logic          exp_perr [NU];
    logic          exp_ferr [NU];
    logic          exp_ovr  [NU];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_param_rx #(.clock_freq(CF), .baud_rate(BR), .data_bits(DB[0]), .parity_mode(PM[0]), .stop_bits(SB[0])) u0 (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .clr(clr_v[0]), .data(d0), .data_rec(rec_w[0]),
        .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .overrun_err(ovr_w[0]), .o_dbg_state(st0));
    uart_param_rx #(.clock_freq(CF), .baud_rate(BR), .data_bits(DB[1]), .parity_mode(PM[1]), .stop_bits(SB[1])) u1 (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .clr(clr_v[1]), .data(d1), .data_rec(rec_w[1]),
        .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .overrun_err(ovr_w[1]), .o_dbg_state(st1));
    uart_param_rx #(.clock_freq(CF), .baud_rate(BR), .data_bits(DB[2]), .parity_mode(PM[2]), .stop_bits(SB[2])) u2 (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .clr(clr_v[2]), .data(d2), .data_rec(rec_w[2]),
        .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .overrun_err(ovr_w[2]), .o_dbg_state(st2));
    uart_param_rx #(.clock_freq(CF), .baud_rate(BR), .data_bits(DB[3]), .parity_mode(PM[3]), .stop_bits(SB[3])) u3 (
        .clk(clk), .rst(rst), .rx(rx_v[3]), .clr(clr_v[3]), .data(d3), .data_rec(rec_w[3]),
        .parity_err(perr_w[3]), .frame_err(ferr_w[3]), .overrun_err(ovr_w[3]), .o_dbg_state(st3));

    function automatic logic [8:0] dmask(input int u);
        return 9'((1 << DB[u]) - 1);
    endfunction

    function automatic logic [8:0] get_data(input int u);
        case (u)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            2:       return {1'b0, d2};
            default: return {2'b00, d3};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_unit(input int u, input string tag);
        chk($sformatf("%s.u%0d.data", tag, u), get_data(u), exp_data[u]);
        chk($sformatf("%s.u%0d.data_rec", tag, u), {8'b0, rec_w[u]}, {8'b0, exp_rec[u]});
        chk($sformatf("%s.u%0d.parity_err", tag, u), {8'b0, perr_w[u]}, {8'b0, exp_perr[u]});
        chk($sformatf("%s.u%0d.frame_err", tag, u), {8'b0, ferr_w[u]}, {8'b0, exp_ferr[u]});
        chk($sformatf("%s.u%0d.overrun_err", tag, u), {8'b0, ovr_w[u]}, {8'b0, exp_ovr[u]});
    endtask

    task automatic reset_model();
        for (int v = 0; v < NU; v++) begin
            exp_data[v] = dmask(v);
            exp_rec[v]  = 1'b0;
            exp_perr[v] = 1'b0;
            exp_ferr[v] = 1'b0;
            exp_ovr[v]  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse(input int u);
        clr_v[u] = 1'b1;
        idle(1);
        clr_v[u] = 1'b0;
        exp_rec[u]  = 1'b0;
        exp_perr[u] = 1'b0;
        exp_ferr[u] = 1'b0;
        exp_ovr[u]  = 1'b0;
    endtask

    // Drives one frame. stop_low bit s pulls stop bit s low; clr_commit raises clr on the
    // commit cycle; rst_at / glitch_at are frame cycle indices (-1 = unused).
    task automatic send(input int u, input logic [8:0] word, input logic bad_par,
                        input logic [1:0] stop_low, input logic clr_commit,
                        input int rst_at, input int glitch_at);
        logic       fb [16];
        logic [8:0] w;
        logic       par_bit;
        logic       pre_rec;
        logic       ferr;
        int         n;
        int         commit_c;
        w = word & dmask(u);
        n = 0;
        fb[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < DB[u]; i++) begin
            fb[n] = w[i];
            n = n + 1;
        end
        if (PM[u] != 0) begin
            par_bit = ($countones(w) % 2 == 1);
            if (PM[u] == 1) par_bit = ~par_bit;
            fb[n] = par_bit ^ bad_par;
            n = n + 1;
        end
        ferr = 1'b0;
        for (int s = 0; s < SB[u]; s++) begin
            fb[n] = ~stop_low[s];
            if (stop_low[s]) ferr = 1'b1;
            n = n + 1;
        end
        commit_c = 3 + HALF + MAJ + (n - 1) * BL;
        pre_rec  = exp_rec[u];
        for (int c = 0; c < n * BL; c++) begin
            rx_v[u]  = fb[c / BL] ^ (c == glitch_at);
            clr_v[u] = clr_commit && (c == commit_c);
            rst      = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
            if (c == commit_c && rst_at < 0)
                chk($sformatf("pre_commit.u%0d.data_rec", u), {8'b0, rec_w[u]}, {8'b0, pre_rec});
            @(posedge clk);
            #1;
        end
        rx_v[u]  = 1'b1;
        clr_v[u] = 1'b0;
        rst      = 1'b0;
        if (rst_at >= 0) begin
            reset_model();
        end else begin
            if (clr_commit)      exp_ovr[u] = 1'b0;
            else if (exp_rec[u]) exp_ovr[u] = 1'b1;
            exp_rec[u]  = 1'b1;
            exp_data[u] = w;
            exp_perr[u] = (PM[u] != 0) && bad_par;
            exp_ferr[u] = ferr;
        end
    endtask

    initial begin
        reset_model();
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(5);
        for (int u = 0; u < NU; u++) chk_unit(u, "reset");

        send(0, 9'h0A5, 1'b0, 2'b00, 1'b0, -1, -1);
        idle(3);
        chk_unit(0, "8n1_a5");
        clr_pulse(0);
        idle(2);
        chk_unit(0, "8n1_clr");

        send(1, 9'h003, 1'b1, 2'b00, 1'b0, -1, -1);
        idle(3);
        chk_unit(1, "8e1_badpar");
        send(1, 9'h003, 1'b0, 2'b00, 1'b0, -1, -1);
        idle(3);
        chk_unit(1, "8e1_goodpar");

        send(2, 9'h05A, 1'b0, 2'b10, 1'b0, -1, -1);
        idle(3);
        chk_unit(2, "8n2_frame");
        idle(2 * BL);
        send(2, 9'h011, 1'b0, 2'b00, 1'b0, -1, -1);
        idle(3);
        chk_unit(2, "8n2_good");

        clr_pulse(0);
        rx_v[0] = 1'b0;
        idle(3);
        rx_v[0] = 1'b1;
        idle(3 * BL);
        chk_unit(0, "glitch");
        send(0, 9'h03C, 1'b0, 2'b00, 1'b0, -1, -1);
        idle(3);
        chk_unit(0, "after_glitch");

        clr_pulse(0);
        send(0, 9'h001, 1'b0, 2'b00, 1'b0, -1, -1);
        send(0, 9'h002, 1'b0, 2'b00, 1'b0, -1, -1);
        idle(3);
        chk_unit(0, "overrun");
        clr_pulse(0);
        send(0, 9'h001, 1'b0, 2'b00, 1'b0, -1, -1);
        send(0, 9'h002, 1'b0, 2'b00, 1'b1, -1, -1);
        idle(3);
        chk_unit(0, "clr_on_commit");

        send(0, 9'h00F, 1'b0, 2'b00, 1'b0, 5 * BL + 3, -1);
        idle(3);
        for (int u = 0; u < NU; u++) chk_unit(u, "mid_reset");
        idle(2 * BL);
        send(0, 9'h0C3, 1'b0, 2'b00, 1'b0, -1, -1);
        idle(3);
        chk_unit(0, "after_reset");

`ifdef UART_RX_MAJORITY_EN
        clr_pulse(0);
        send(0, 9'h000, 1'b0, 2'b00, 1'b0, -1, BL + HALF + 1);
        idle(3);
        chk_unit(0, "majority");
`endif

        for (int k = 0; k < 24; k++) begin
            int         u;
            logic [8:0] word;
            logic       bad_par;
            logic [1:0] stop_low;
            logic       clr_c;
            u        = $urandom_range(0, NU - 1);
            word     = 9'($urandom_range(0, 511));
            bad_par  = 1'($urandom_range(0, 1));
            stop_low = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            clr_c    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) clr_pulse(u);
            send(u, word, bad_par, stop_low, clr_c, -1, -1);
            idle(3);
            chk_unit(u, $sformatf("rand%0d", k));
            idle(BL + $urandom_range(0, BL));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
